trigonometry_lut: RTL and testbench



---
 rtl/trig_pkg.sv | 29 ++
 rtl/sin_quarter_rom.sv | 16 +
 rtl/trigonometry_lut.sv | 110 +++++++++++
 tb/tb_trigonometry_lut.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// rtl/trig_pkg.sv - shared constants, quadrant type and quarter-wave sine table
package trig_pkg;

  localparam int FRAC_BITS  = 10;
  localparam int ONE        = 1 << FRAC_BITS;
  localparam int TABLE_LAST = 90;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  // S[d] = round(1024 * sin(d degrees)), d = 0..90
  localparam logic [10:0] SIN_TABLE [0:90] = '{
    11'd0,    11'd18,   11'd36,   11'd54,   11'd71,   11'd89,   11'd107,  11'd125,  11'd143,  11'd160,
    11'd178,  11'd195,  11'd213,  11'd230,  11'd248,  11'd265,  11'd282,  11'd299,  11'd316,  11'd333,
    11'd350,  11'd367,  11'd384,  11'd400,  11'd416,  11'd433,  11'd449,  11'd465,  11'd481,  11'd496,
    11'd512,  11'd527,  11'd543,  11'd558,  11'd573,  11'd587,  11'd602,  11'd616,  11'd630,  11'd644,
    11'd658,  11'd672,  11'd685,  11'd698,  11'd711,  11'd724,  11'd737,  11'd749,  11'd761,  11'd773,
    11'd784,  11'd796,  11'd807,  11'd818,  11'd828,  11'd839,  11'd849,  11'd859,  11'd868,  11'd878,
    11'd887,  11'd896,  11'd904,  11'd912,  11'd920,  11'd928,  11'd935,  11'd943,  11'd949,  11'd956,
    11'd962,  11'd968,  11'd974,  11'd979,  11'd984,  11'd989,  11'd994,  11'd998,  11'd1002, 11'd1005,
    11'd1008, 11'd1011, 11'd1014, 11'd1016, 11'd1018, 11'd1020, 11'd1022, 11'd1023, 11'd1023, 11'd1024,
    11'd1024
  };

endpackage

// File: rtl/sin_quarter_rom.sv
// rtl/sin_quarter_rom.sv - combinational quarter-wave sine lookup, index 0..90
module sin_quarter_rom
  import trig_pkg::*;
(
  input  logic [6:0]  idx_i,
  output logic [10:0] val_o
);

  always_comb begin
    val_o = '0;
    if (idx_i <= 7'(TABLE_LAST)) begin
      val_o = SIN_TABLE[idx_i];
    end
  end

endmodule

// File: rtl/trigonometry_lut.sv
// rtl/trigonometry_lut.sv - two-stage Q.10 sine/cosine of an integer-degree angle
module trigonometry_lut
  import trig_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic signed [31:0] i_theta,
  output logic signed [31:0] o_cos,
  output logic signed [31:0] o_sin
);

  logic [31:0] theta_u;
  logic [16:0] fold_sum;
  logic [8:0]  quot;
  logic [16:0] rem_raw;
  logic [8:0]  angle;
  quadrant_e   quad_d, quad_q;
  logic [6:0]  off_d, off_q;
  logic [10:0] mag_off, mag_mir;
  logic signed [31:0] cos_d, cos_q, sin_d, sin_q;

  assign theta_u = i_theta;

  // Byte-wise residues: 2^8, 2^16, 2^24 mod 360 = 256, 16, 136; a negative
  // input adds -(2^32 mod 360) = -256, i.e. +104, giving the Euclidean result.
  always_comb begin
    fold_sum = 17'(theta_u[31:24]) * 17'd136
             + 17'(theta_u[23:16]) * 17'd16
             + {1'b0, theta_u[15:8], 8'd0}
             + 17'(theta_u[7:0])
             + (theta_u[31] ? 17'd104 : 17'd0);
    // floor(2^26/360) underestimates the quotient by at most one
    quot    = 9'(({18'd0, fold_sum} * 35'd186413) >> 26);
    rem_raw = fold_sum - 17'(quot) * 17'd360;
    angle   = (rem_raw >= 17'd360) ? 9'(rem_raw - 17'd360) : 9'(rem_raw);
  end

  always_comb begin
    quad_d = Q0;
    off_d  = 7'(angle);
    if (angle > 9'd270) begin
      quad_d = Q3;
      off_d  = 7'(angle - 9'd270);
    end else if (angle > 9'd180) begin
      quad_d = Q2;
      off_d  = 7'(angle - 9'd180);
    end else if (angle > 9'd90) begin
      quad_d = Q1;
      off_d  = 7'(angle - 9'd90);
    end
  end

  sin_quarter_rom u_rom_off (
    .idx_i (off_q),
    .val_o (mag_off)
  );

  sin_quarter_rom u_rom_mir (
    .idx_i (7'(TABLE_LAST) - off_q),
    .val_o (mag_mir)
  );

  function automatic logic signed [31:0] apply_sign(input logic [10:0] mag, input logic neg);
    logic signed [31:0] m;
    m = signed'({21'd0, mag});
    return neg ? -m : m;
  endfunction

  always_comb begin
    sin_d = apply_sign(mag_off, 1'b0);
    cos_d = apply_sign(mag_mir, 1'b0);
    case (quad_q)
      Q0: begin
        sin_d = apply_sign(mag_off, 1'b0);
        cos_d = apply_sign(mag_mir, 1'b0);
      end
      Q1: begin
        sin_d = apply_sign(mag_mir, 1'b0);
        cos_d = apply_sign(mag_off, 1'b1);
      end
      Q2: begin
        sin_d = apply_sign(mag_off, 1'b1);
        cos_d = apply_sign(mag_mir, 1'b1);
      end
      Q3: begin
        sin_d = apply_sign(mag_mir, 1'b1);
        cos_d = apply_sign(mag_off, 1'b0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      quad_q <= Q0;
      off_q  <= '0;
      cos_q  <= ONE;
      sin_q  <= '0;
    end else begin
      quad_q <= quad_d;
      off_q  <= off_d;
      cos_q  <= cos_d;
      sin_q  <= sin_d;
    end
  end

  assign o_cos = cos_q;
  assign o_sin = sin_q;

endmodule

// File: tb/tb_trigonometry_lut.sv
// tb/tb_trigonometry_lut.sv - self-checking bench for trigonometry_lut
module tb_trigonometry_lut;

  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [31:0] theta;
  logic signed [31:0] cos_o;
  logic signed [31:0] sin_o;

  always #5 clk = ~clk;

  trigonometry_lut dut (
    .i_clock (clk),
    .i_RESET (rst_n),
    .i_theta (theta),
    .o_cos   (cos_o),
    .o_sin   (sin_o)
  );

  typedef struct { int theta; int exp_cos; int exp_sin; } vec_t;
  typedef struct { int exp_cos; int exp_sin; int due; int theta; } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic int q10(input real x);
    real r;
    r = 1024.0 * x;
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  function automatic int emod360(input int t);
    longint m;
    m = longint'(t) % 64'sd360;
    if (m < 0) m = m + 360;
    return int'(m);
  endfunction

  function automatic int ref_cos(input int t);
    return q10($cos(real'(emod360(t)) * PI / 180.0));
  endfunction

  function automatic int ref_sin(input int t);
    return q10($sin(real'(emod360(t)) * PI / 180.0));
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    int c;
    int s;
    @(negedge clk);
    cyc++;
    c = cos_o;
    s = sin_o;
    check("cos_range", int'(c >= -1024 && c <= 1024), 1);
    check("sin_range", int'(s >= -1024 && s <= 1024), 1);
    while (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (cos_o !== e.exp_cos)
        $display("  theta=%0d cos", e.theta);
      check("cos", cos_o, e.exp_cos);
      if (sin_o !== e.exp_sin)
        $display("  theta=%0d sin", e.theta);
      check("sin", sin_o, e.exp_sin);
    end
  endtask

  task automatic drive(input int t, input int ec, input int es);
    theta = t;
    sb.push_back('{ec, es, cyc + 2, t});
  endtask

  initial begin
    vecs[0] = '{30, 887, 512};
    vecs[1] = '{90, 0, 1024};
    vecs[2] = '{180, -1024, 0};
    vecs[3] = '{270, 0, -1024};
    vecs[4] = '{390, 887, 512};
    vecs[5] = '{-90, 0, -1024};
    vecs[6] = '{-1, 1024, -18};
    vecs[7] = '{360, 1024, 0};
    vecs[8] = '{32'sh8000_0000, -630, -807};
    vecs[9] = '{32'sh7fff_ffff, -616, 818};

    rst_n = 1'b0;
    theta = 0;
    repeat (3) begin
      tick();
      check("reset_cos", cos_o, 1024);
      check("reset_sin", sin_o, 0);
    end

    rst_n = 1'b1;
    drive(0, 1024, 0);
    repeat (5) begin
      tick();
      check("release_cos", cos_o, 1024);
      check("release_sin", sin_o, 0);
      drive(0, 1024, 0);
    end

    for (int i = 0; i < 10; i++) begin
      tick();
      drive(vecs[i].theta, vecs[i].exp_cos, vecs[i].exp_sin);
    end

    for (int t = -720; t <= 720; t++) begin
      tick();
      drive(t, ref_cos(t), ref_sin(t));
    end

    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom());
      tick();
      drive(r, ref_cos(r), ref_sin(r));
    end

    for (int i = 0; i < 4; i++) begin
      tick();
      drive(45, 724, 724);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_cos", cos_o, 1024);
    check("async_reset_sin", sin_o, 0);
    sb.delete();
    tick();
    check("hold_reset_cos", cos_o, 1024);
    check("hold_reset_sin", sin_o, 0);
    tick();
    rst_n = 1'b1;
    sb.push_back('{1024, 0, cyc + 1, 0});
    drive(45, 724, 724);
    repeat (3) begin
      tick();
      drive(45, 724, 724);
    end

    repeat (3) tick();
    check("scoreboard_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
